crf_frame_sequencer: RTL and testbench

AXI4-Lite master that drives the upsampler's configuration register file through a multi-frame run without a host CPU. Per frame it writes the start register, waits for the `interrupt_updone` edge from the register file, then writes the end register, counting frames and detecting bus errors, timeouts and aborts. It sits beside the access-control / bicubic datapath top and drives the config register file's `s_axi_*` write channel. The top ties off the read channel.

---
 rtl/crf_frame_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_crf_frame_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crf_frame_sequencer.sv
// AXI4-Lite write master that steps the upsampler register file through a multi-frame run:
// start write, wait for the done edge, end write, repeat; reports done, bus errors, timeouts and aborts.
module crf_frame_sequencer #(
  parameter int unsigned               AXI_DATA_WIDTH = 32,
  parameter int unsigned               AXI_ADDR_WIDTH = 32,
  parameter int unsigned               FRAME_W        = 16,
  parameter int unsigned               TIMEOUT_W      = 24,
  parameter logic [AXI_ADDR_WIDTH-1:0] UPSTR_ADDR     = 'h0,
  parameter logic [AXI_ADDR_WIDTH-1:0] UPENDR_ADDR    = 'h4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          seq_start,
  input  logic                          seq_abort,
  input  logic [FRAME_W-1:0]            seq_nframes,
  input  logic [TIMEOUT_W-1:0]          seq_timeout,
  input  logic                          interrupt_updone,
  output logic                          m_axi_awvalid,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  input  logic                          m_axi_awready,
  output logic                          m_axi_wvalid,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  input  logic                          m_axi_wready,
  input  logic                          m_axi_bvalid,
  input  logic [1:0]                    m_axi_bresp,
  output logic                          m_axi_bready,
  output logic                          seq_busy,
  output logic                          seq_done,
  output logic                          seq_err,
  output logic [1:0]                    seq_err_code,
  output logic [FRAME_W-1:0]            seq_frame_cnt
);

  typedef enum logic [2:0] {
    IDLE, WR_START, B_START, WAIT_DONE, WR_END, B_END, NEXT
  } state_t;

  state_t               state;
  logic [FRAME_W-1:0]   nframes;
  logic [TIMEOUT_W-1:0] timeout;
  logic [TIMEOUT_W-1:0] tcnt;
  logic                 aw_done, w_done, abort_pend, updone_q;
  logic                 aw_hs, w_hs, aw_fin, w_fin, ud_edge;

  assign m_axi_awprot = '0;
  assign m_axi_wstrb  = '1;

  always_comb begin
    aw_hs   = m_axi_awvalid & m_axi_awready;
    w_hs    = m_axi_wvalid & m_axi_wready;
    aw_fin  = aw_done | aw_hs;
    w_fin   = w_done | w_hs;
    ud_edge = interrupt_updone & ~updone_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      nframes       <= '0;
      timeout       <= '0;
      tcnt          <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      abort_pend    <= 1'b0;
      updone_q      <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= UPSTR_ADDR;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_bready  <= 1'b0;
      seq_busy      <= 1'b0;
      seq_done      <= 1'b0;
      seq_err       <= 1'b0;
      seq_err_code  <= '0;
      seq_frame_cnt <= '0;
    end else begin
      seq_done <= 1'b0;
      updone_q <= interrupt_updone;
      case (state)
        IDLE: begin
          if (seq_start) begin
            nframes       <= seq_nframes;
            timeout       <= seq_timeout;
            seq_frame_cnt <= '0;
            seq_err       <= 1'b0;
            seq_err_code  <= '0;
            abort_pend    <= 1'b0;
            if (seq_nframes == '0) begin
              seq_done <= 1'b1;
            end else begin
              state         <= WR_START;
              seq_busy      <= 1'b1;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              m_axi_awaddr  <= UPSTR_ADDR;
              m_axi_wdata   <= AXI_DATA_WIDTH'(1);
            end
          end
        end
        WR_START, WR_END: begin
          if (seq_abort) abort_pend <= 1'b1;
          if (aw_hs) m_axi_awvalid <= 1'b0;
          if (w_hs)  m_axi_wvalid  <= 1'b0;
          // AW and W complete independently; remember which one already finished
          if (aw_fin && w_fin) begin
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            m_axi_bready <= 1'b1;
            state        <= (state == WR_START) ? B_START : B_END;
          end else begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
          end
        end
        B_START, B_END: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != 2'b00) begin
              state        <= IDLE;
              seq_busy     <= 1'b0;
              seq_err      <= 1'b1;
              seq_err_code <= 2'b01;
            end else if (abort_pend || seq_abort) begin
              state        <= IDLE;
              seq_busy     <= 1'b0;
              seq_err      <= 1'b1;
              seq_err_code <= 2'b11;
            end else if (state == B_START) begin
              state <= WAIT_DONE;
              tcnt  <= '0;
            end else begin
              state <= NEXT;
            end
          end else if (seq_abort) begin
            abort_pend <= 1'b1;
          end
        end
        WAIT_DONE: begin
          if (seq_abort) begin
            state        <= IDLE;
            seq_busy     <= 1'b0;
            seq_err      <= 1'b1;
            seq_err_code <= 2'b11;
          end else if (ud_edge) begin
            state         <= WR_END;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            m_axi_awaddr  <= UPENDR_ADDR;
          end else if (timeout != '0 && tcnt == timeout - TIMEOUT_W'(1)) begin
            state        <= IDLE;
            seq_busy     <= 1'b0;
            seq_err      <= 1'b1;
            seq_err_code <= 2'b10;
          end else begin
            tcnt <= tcnt + TIMEOUT_W'(1);
          end
        end
        NEXT: begin
          seq_frame_cnt <= seq_frame_cnt + FRAME_W'(1);
          if (seq_abort) begin
            state        <= IDLE;
            seq_busy     <= 1'b0;
            seq_err      <= 1'b1;
            seq_err_code <= 2'b11;
          end else if (seq_frame_cnt + FRAME_W'(1) == nframes) begin
            state    <= IDLE;
            seq_busy <= 1'b0;
            seq_done <= 1'b1;
          end else begin
            state         <= WR_START;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            m_axi_awaddr  <= UPSTR_ADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crf_frame_sequencer.sv
// Scoreboard bench for crf_frame_sequencer: stimulus pushes expected writes, frame counts and
// completion events; a negedge monitor pops and compares them as the DUT presents them.
module tb_crf_frame_sequencer;
  localparam int AW = 32, DW = 32, FW = 16, TW = 24;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          seq_start = 1'b0, seq_abort = 1'b0;
  logic [FW-1:0] seq_nframes = '0;
  logic [TW-1:0] seq_timeout = '0;
  logic          interrupt_updone;
  logic          updone_gen = 1'b0, ud_force = 1'b0;
  logic          m_axi_awvalid, m_axi_awready = 1'b0;
  logic [AW-1:0] m_axi_awaddr;
  logic [2:0]    m_axi_awprot;
  logic          m_axi_wvalid, m_axi_wready = 1'b0;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic          m_axi_bvalid = 1'b0, m_axi_bready;
  logic [1:0]    m_axi_bresp = 2'b00;
  logic          seq_busy, seq_done, seq_err;
  logic [1:0]    seq_err_code;
  logic [FW-1:0] seq_frame_cnt;

  assign interrupt_updone = updone_gen | ud_force;

  crf_frame_sequencer #(
    .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .FRAME_W(FW), .TIMEOUT_W(TW),
    .UPSTR_ADDR(32'h0), .UPENDR_ADDR(32'h4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seq_start(seq_start), .seq_abort(seq_abort),
    .seq_nframes(seq_nframes), .seq_timeout(seq_timeout), .interrupt_updone(interrupt_updone),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awready(m_axi_awready), .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wready(m_axi_wready), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready), .seq_busy(seq_busy),
    .seq_done(seq_done), .seq_err(seq_err), .seq_err_code(seq_err_code),
    .seq_frame_cnt(seq_frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; int len; int cyc; } aw_exp_t;
  typedef struct { logic done; logic err; logic [1:0] code; int fc; int cyc; } end_exp_t;
  aw_exp_t  aw_q[$];
  int       w_q[$];
  int       fc_q[$];
  end_exp_t end_q[$];
  aw_exp_t  ea;
  end_exp_t ee;

  int tests = 0, fails = 0;
  int end_cnt = 0, b_count = 0, outstanding = 0;
  int aw_run = 0, w_run = 0, ud_timer = 0, ud_hold = 0;
  int aw_delay = 0, w_delay = 0, b_delay = 0, b_err_at = -1;
  int aw_wait = 0, w_wait = 0, b_wait = 0;
  logic ud_en = 1'b1, err_prev = 1'b0, done_prev = 1'b0;
  logic [31:0] aw_addr_prev = '0, last_addr = '0;
  logic [FW-1:0] fc_prev = '0;

  function automatic void chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endfunction

  function automatic void miss(string name);
    tests++;
    fails++;
    $display("FAIL %s: DUT event with no expectation queued at cycle %0d", name, cyc);
  endfunction

  // Slave: per-channel ready/valid delay counters, bresp error on a chosen B beat
  always @(posedge clk) begin
    #1;
    if (!m_axi_awvalid) aw_wait = 0;
    m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
    if (m_axi_awvalid) aw_wait++;
    if (!m_axi_wvalid) w_wait = 0;
    m_axi_wready = m_axi_wvalid && (w_wait >= w_delay);
    if (m_axi_wvalid) w_wait++;
    if (!m_axi_bready) b_wait = 0;
    m_axi_bvalid = m_axi_bready && (b_wait >= b_delay);
    if (m_axi_bready) b_wait++;
    m_axi_bresp = (b_count == b_err_at) ? 2'b10 : 2'b00;
  end

  // Monitor: also plays the register file, raising updone 10 cycles after each start-write B
  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0; aw_run = 0; w_run = 0;
      err_prev = 1'b0; done_prev = 1'b0; fc_prev = '0;
    end else begin
      if (ud_hold > 0) begin ud_hold--; if (ud_hold == 0) updone_gen = 1'b0; end
      if (ud_timer > 0) begin
        ud_timer--;
        if (ud_timer == 0) begin updone_gen = 1'b1; ud_hold = 3; end
      end
      if (m_axi_awvalid) begin
        aw_run++;
        if (aw_run > 1) chk("awaddr_stable", m_axi_awaddr, aw_addr_prev);
        aw_addr_prev = m_axi_awaddr;
      end else aw_run = 0;
      if (m_axi_wvalid) w_run++; else w_run = 0;
      if (m_axi_awvalid && m_axi_awready) begin
        chk("aw_outstanding", outstanding, 0);
        outstanding++;
        last_addr = m_axi_awaddr;
        chk("awprot", m_axi_awprot, 0);
        if (aw_q.size() == 0) miss("unexpected_aw");
        else begin
          ea = aw_q.pop_front();
          chk("awaddr", m_axi_awaddr, ea.addr);
          chk("aw_len", aw_run, ea.len);
          if (ea.cyc >= 0) chk("aw_cycle", cyc, ea.cyc);
        end
        aw_run = 0;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (w_q.size() == 0) miss("unexpected_w");
        else begin
          chk("wdata", m_axi_wdata, 1);
          chk("wstrb", m_axi_wstrb, 'hF);
          chk("w_len", w_run, w_q.pop_front());
        end
        w_run = 0;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        chk("b_outstanding", outstanding, 1);
        outstanding--;
        b_count++;
        if (ud_en && m_axi_bresp == 2'b00 && last_addr == 32'h0) ud_timer = 10;
      end
      if (seq_frame_cnt != fc_prev && seq_frame_cnt != '0) begin
        if (fc_q.size() == 0) miss("unexpected_frame_cnt");
        else chk("frame_cnt_step", seq_frame_cnt, fc_q.pop_front());
      end
      fc_prev = seq_frame_cnt;
      if (seq_done) chk("done_width", done_prev, 0);
      if (seq_done || (seq_err && !err_prev)) begin
        end_cnt++;
        if (end_q.size() == 0) miss("unexpected_end");
        else begin
          ee = end_q.pop_front();
          chk("end_done", seq_done, ee.done);
          chk("end_err", seq_err, ee.err);
          chk("end_code", seq_err_code, ee.code);
          chk("end_frame_cnt", seq_frame_cnt, ee.fc);
          chk("end_busy", seq_busy, 0);
          if (ee.cyc >= 0) chk("end_cycle", cyc, ee.cyc);
        end
      end
      err_prev  = seq_err;
      done_prev = seq_done;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [FW-1:0] nf, input logic [TW-1:0] to, output int t);
    tick();
    seq_nframes = nf; seq_timeout = to; seq_start = 1'b1; t = cyc;
    tick();
    seq_start = 1'b0;
  endtask

  task automatic wait_end(input int base, input int lim);
    int n = 0;
    while (end_cnt == base && n < lim) begin tick(); n++; end
    tests++;
    if (end_cnt == base) begin
      fails++;
      $display("FAIL wait_end: no completion event within %0d cycles", lim);
    end
    repeat (20) tick();
  endtask

  task automatic push_aw(input logic [31:0] a, input int len, input int c, input int wlen);
    aw_q.push_back('{a, len, c});
    w_q.push_back(wlen);
  endtask

  task automatic push_end(input logic d, input logic e, input logic [1:0] code, input int fc, input int c);
    end_q.push_back('{d, e, code, fc, c});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awvalid"}, m_axi_awvalid, 0);
    chk({tag, "_wvalid"}, m_axi_wvalid, 0);
    chk({tag, "_bready"}, m_axi_bready, 0);
    chk({tag, "_awaddr"}, m_axi_awaddr, 0);
    chk({tag, "_wdata"}, m_axi_wdata, 0);
    chk({tag, "_wstrb"}, m_axi_wstrb, 'hF);
    chk({tag, "_busy"}, seq_busy, 0);
    chk({tag, "_done"}, seq_done, 0);
    chk({tag, "_err"}, seq_err, 0);
    chk({tag, "_code"}, seq_err_code, 0);
    chk({tag, "_fc"}, seq_frame_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, base, n;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // 3 frames, zero-wait slave, plus an ignored start while busy
    base = end_cnt;
    run(3, 0, t);
    chk("busy_at_T1", seq_busy, 1);
    chk("awvalid_at_T1", m_axi_awvalid, 1);
    push_aw(32'h0, 1, t + 1, 1); push_aw(32'h4, 1, -1, 1);
    push_aw(32'h0, 1, -1, 1);    push_aw(32'h4, 1, -1, 1);
    push_aw(32'h0, 1, -1, 1);    push_aw(32'h4, 1, -1, 1);
    fc_q.push_back(1); fc_q.push_back(2); fc_q.push_back(3);
    push_end(1'b1, 1'b0, 2'b00, 3, -1);
    repeat (4) tick();
    seq_nframes = '0; seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
    wait_end(base, 400);

    // AW stalled 3 cycles, W immediate
    aw_delay = 3;
    base = end_cnt;
    run(1, 0, t);
    push_aw(32'h0, 4, t + 4, 1); push_aw(32'h4, 4, -1, 1);
    fc_q.push_back(1);
    push_end(1'b1, 1'b0, 2'b00, 1, -1);
    wait_end(base, 200);
    aw_delay = 0;

    // SLVERR on the end write of frame 1
    b_err_at = b_count + 1;
    base = end_cnt;
    run(2, 0, t);
    push_aw(32'h0, 1, -1, 1); push_aw(32'h4, 1, -1, 1);
    push_end(1'b0, 1'b1, 2'b01, 0, -1);
    wait_end(base, 200);
    b_err_at = -1;

    // Timeout 50, updone never rises
    ud_en = 1'b0;
    base = end_cnt;
    run(1, 50, t);
    push_aw(32'h0, 1, t + 1, 1);
    push_end(1'b0, 1'b1, 2'b10, 0, t + 53);
    wait_end(base, 200);

    // Timeout 1: expires on the first WAIT_DONE cycle
    base = end_cnt;
    run(1, 1, t);
    push_aw(32'h0, 1, -1, 1);
    push_end(1'b0, 1'b1, 2'b10, 0, t + 4);
    wait_end(base, 100);

    // updone already high on entry is not an edge
    ud_force = 1'b1;
    base = end_cnt;
    run(1, 20, t);
    push_aw(32'h0, 1, -1, 1);
    push_end(1'b0, 1'b1, 2'b10, 0, t + 23);
    wait_end(base, 100);
    ud_force = 1'b0;
    repeat (3) tick();

    // Abort while WR_START is stalled: write and B finish, then abort
    aw_delay = 4; w_delay = 4;
    base = end_cnt;
    run(2, 0, t);
    seq_abort = 1'b1;
    tick();
    seq_abort = 1'b0;
    push_aw(32'h0, 5, t + 5, 5);
    push_end(1'b0, 1'b1, 2'b11, 0, t + 7);
    wait_end(base, 100);
    aw_delay = 0; w_delay = 0;

    // Abort in WAIT_DONE takes effect next cycle
    base = end_cnt;
    run(1, 0, t);
    push_aw(32'h0, 1, -1, 1);
    repeat (5) tick();
    seq_abort = 1'b1; n = cyc;
    tick();
    seq_abort = 1'b0;
    push_end(1'b0, 1'b1, 2'b11, 0, n + 1);
    wait_end(base, 100);
    ud_en = 1'b1;

    // nframes = 0: done next cycle, no bus traffic
    base = end_cnt;
    run(0, 0, t);
    push_end(1'b1, 1'b0, 2'b00, 0, t + 1);
    wait_end(base, 20);

    // Reset asserted while parked in B_END
    run(1, 0, t);
    push_aw(32'h0, 1, -1, 1); push_aw(32'h4, 1, -1, 1);
    n = 0;
    while (!(m_axi_awvalid && m_axi_awaddr == 32'h4) && n < 200) begin tick(); n++; end
    chk("reach_wr_end", m_axi_awaddr, 32'h4);
    b_delay = 100;
    repeat (3) tick();
    chk("parked_bready", m_axi_bready, 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    b_delay = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();

    // Clean run after reset
    base = end_cnt;
    run(2, 0, t);
    push_aw(32'h0, 1, t + 1, 1); push_aw(32'h4, 1, -1, 1);
    push_aw(32'h0, 1, -1, 1);    push_aw(32'h4, 1, -1, 1);
    fc_q.push_back(1); fc_q.push_back(2);
    push_end(1'b1, 1'b0, 2'b00, 2, -1);
    wait_end(base, 300);

    chk("aw_q_empty", aw_q.size(), 0);
    chk("w_q_empty", w_q.size(), 0);
    chk("fc_q_empty", fc_q.size(), 0);
    chk("end_q_empty", end_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
